// File: rtl/modmul_pkg.sv
// Shared types and constants for the radix-2^R modular multiplier/adder.
package modmul_pkg;

  // Operation selected by in_mode.
  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_SQR = 2'd1,
    MODE_ADD = 2'd2,
    MODE_SUB = 2'd3
  } mode_e;

  // One-hot controller state encoding.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'b001;
  localparam state_t ST_RUN  = 3'b010;
  localparam state_t ST_HOLD = 3'b100;

  // Width of the iteration counter: it must be able to count N/R digits.
  function automatic int cnt_width(input int n, input int r);
    return $clog2(n / r + 1);
  endfunction

endpackage

// File: rtl/modmul_step.sv
// One radix-2 interleaved-reduction sub-step:
// acc' = (2*acc + bit*bp) mod m, given acc < m and bp < m.
module modmul_step #(
  parameter int N = 256
) (
  input  logic [N-1:0] acc_i,
  input  logic         bit_i,
  input  logic [N-1:0] bp_i,
  input  logic [N-1:0] m_i,
  output logic [N-1:0] acc_o
);

  // 2*acc + bp < 3m, so two conditional subtractions restore acc' < m.
  logic [N+1:0] mx;
  logic [N+1:0] t0;
  logic [N+1:0] t1;

  // Double, add the selected multiplicand, then reduce at most twice.
  always_comb begin
    // NOTE: blocking assignments are correct in combinational logic; each
    // line reads the value computed by the line above it.
    mx    = {2'b00, m_i};
    t0    = {1'b0, acc_i, 1'b0} + {2'b00, (bit_i ? bp_i : '0)};
    t1    = (t0 >= mx) ? t0 - mx : t0;
    acc_o = (t1 >= mx) ? N'(t1 - mx) : N'(t1);
  end

endmodule

// File: rtl/modmul_radix.sv
// Iterative (a op b) mod m with valid/ready handshakes. MUL/SQR retire R
// multiplier bits per cycle through a chain of R modmul_step instances;
// ADD/SUB complete in a single RUN cycle. Results are held until taken.
module modmul_radix
  import modmul_pkg::*;
#(
  parameter int N = 256,
  parameter int R = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_err
);

  localparam int NDIG = N / R;
  localparam int CW   = cnt_width(N, R);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (N < 4 || R < 1 || R > N || (N % R) != 0) begin : g_bad_params
    $error("modmul_radix: N must be >= 4 and a multiple of R, with 1 <= R <= N");
  end

  state_t        state_q, state_d;
  mode_e         mode_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;      // b' : holds a for SQR, b otherwise
  logic [N-1:0]  m_q;
  logic [N-1:0]  mult_q;   // multiplier, shifted left R bits per cycle
  logic [N-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  result_q;
  logic          err_q;

  logic          accept;
  logic          chk_fail;
  logic          is_mul;
  logic          last_run;
  logic [N-1:0]  addsub_res;
  logic [N:0]    sum;
  logic [N:0]    diff_wrap;

  // Step chain: chain[0] is the registered accumulator, chain[R] the value
  // after this cycle's R multiplier bits (MSB first).
  logic [N-1:0]  chain [R+1];

  assign chain[0] = acc_q;

  for (genvar g = 0; g < R; g++) begin : g_step
    modmul_step #(.N(N)) u_step (
      .acc_i (chain[g]),
      .bit_i (mult_q[N-1-g]),
      .bp_i  (b_q),
      .m_i   (m_q),
      .acc_o (chain[g+1])
    );
  end

  assign accept   = in_valid & in_ready;
  assign chk_fail = (in_m < N'(2)) || (in_a >= in_m) ||
                    ((in_mode != MODE_SQR) && (in_b >= in_m));
  assign is_mul   = (mode_q == MODE_MUL) || (mode_q == MODE_SQR);
  assign last_run = is_mul ? (cnt_q == LAST) : 1'b1;

  // Single-cycle modular add/subtract on the latched operands (a, b < m).
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff_wrap  = {1'b0, a_q} + {1'b0, m_q} - {1'b0, b_q};
    addsub_res = '0;
    if (mode_q == MODE_ADD) begin
      addsub_res = (sum >= {1'b0, m_q}) ? N'(sum - {1'b0, m_q}) : N'(sum);
    end else begin
      addsub_res = (a_q >= b_q) ? a_q - b_q : N'(diff_wrap);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = chk_fail ? ST_HOLD : ST_RUN;
      ST_RUN:  if (last_run)  state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; result and error are only shown in HOLD.
  always_comb begin
    in_ready   = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_HOLD);
    out_result = out_valid ? result_q : '0;
    out_err    = out_valid & err_q;
  end

  // Operand capture on accept, iteration and result update during RUN.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the operand and accumulator registers are reset as well, so an
    // aborted operation leaves nothing behind for the next one.
    if (reset) begin
      mode_q   <= MODE_MUL;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      mult_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      mode_q   <= mode_e'(in_mode);
      a_q      <= in_a;
      b_q      <= (in_mode == MODE_SQR) ? in_a : in_b;
      m_q      <= in_m;
      mult_q   <= in_a;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= chk_fail;
    end else if (state_q == ST_RUN) begin
      acc_q  <= chain[R];
      mult_q <= mult_q << R;
      cnt_q  <= cnt_q + CW'(1);
      if (last_run) begin
        result_q <= is_mul ? chain[R] : addsub_res;
      end
    end
  end

endmodule

// File: doc/modmul_radix.md
# modmul_radix

Iterative modular multiplier/adder computing (a op b) mod m on N-bit operands, retiring R multiplier bits per cycle (radix 2^R). It replaces the fixed radix-2, start/done modular multiplier in the arithmetic datapath and adds three things: a configurable digit width, an operation mode input, and valid/ready handshakes with result hold under back-pressure. It sits between the operand scheduler and the result FIFO.

## Interface
- N, 256: operand/modulus width in bits. N ≥ 4.
- R, 4: multiplier bits consumed per iteration cycle. 1 ≤ R ≤ N. N % R must be 0; otherwise elaboration fails.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block accepts an operand set; high only in IDLE.
- in_mode  in  2  0=MUL a·b, 1=SQR a·a (b ignored), 2=ADD a+b, 3=SUB a−b; all mod m.
- in_a, in_b, in_m  in  N each  operands and modulus.
- out_valid  out  1  result available and held.
- out_ready  in  1  consumer accepts the result.
- out_result  out  N  result in [0, m−1]; 0 when out_err=1.
- out_err  out  1  operand check failed.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_err=0.

## Operation
- Accept: in_valid & in_ready at a rising edge. a, b, m and mode are latched; the input bus is don't-care afterwards.
- Check at accept: if m < 2, a ≥ m, or b ≥ m (b is not checked for SQR), go straight to HOLD with out_err=1 and out_result=0.
- MUL/SQR: interleaved reduction, MSB first. The accumulator acc starts at 0. Each cycle performs R sub-steps, for bit j of the multiplier, from bit N−1 down to bit 0:
  - acc = 2·acc + a[j]·b'
  - subtract m while acc ≥ m, at most twice.
  - b' = b for MUL, b' = a for SQR.
  - Invariant: acc < m after every sub-step. Intermediate width is N+2 bits.
- ADD: s = a + b (N+1 bits); result = s − m if s ≥ m, else s.
- SUB: result = a − b if a ≥ b, else a − b + m.
- FSM states:
  - IDLE: on accept, go to RUN, or to HOLD if the check fails.
  - RUN: a cycle counter counts N/R cycles for MUL/SQR and 1 cycle for ADD/SUB; on the last count, go to HOLD.
  - HOLD: out_valid=1. When out_ready=1, go to IDLE.
- HOLD holds out_result and out_err stable until the handshake. The next operand cannot be accepted in the same cycle as the out handshake; in_ready rises the cycle after.
- Reset asserted in any state: returns to IDLE immediately (asynchronous). The in-flight operation is discarded and produces no output.

## Timing
- Accept edge is cycle 0.
- MUL/SQR: out_valid rises at edge N/R + 1. For N=256, R=4 that is 65 cycles.
- ADD/SUB: out_valid at edge 2.
- Error: out_valid at edge 1.
- Throughput: one operation per (latency + 1) cycles when out_ready is held high.
- Critical path: R chained sub-steps, each an N+2-bit add and two compare/subtracts. R trades area and frequency against latency.

## Structure
- Package modmul_pkg holds:
  - the mode enum (MODE_MUL, MODE_SQR, MODE_ADD, MODE_SUB)
  - the one-hot state constants (ST_IDLE, ST_RUN, ST_HOLD)
  - a function giving counter width = $clog2(N/R + 1).
- Sub-module modmul_step: combinational, one radix-2 sub-step (acc, bit, b', m → acc'), parametrised by N. The top instantiates R of them in a chain via a generate loop. The top keeps the FSM, counter, operand registers, ADD/SUB path and handshakes.

## Test plan
- N=8, R=2, MUL, a=200, b=150, m=251 → out_result=131, out_err=0, out_valid at edge 5.
- N=8, R=2, SQR, a=250, m=251 → out_result=1. ADD a=200, b=100 → 49 at edge 2. SUB a=10, b=20 → 241.
- Error: m=1, or MUL with a=251, m=251 → out_err=1, out_result=0, out_valid at edge 1. Next op is accepted normally after the handshake.
- Back-pressure: out_ready low for 5 cycles after out_valid → result and out_err stable, in_ready=0 throughout. out_ready high → IDLE next cycle, in_ready=1.
- Reset mid-RUN (edge 2 of MUL) → outputs return to reset values immediately. A new MUL afterwards gives the correct result with no residue.
- Random sweep for N ∈ {8, 64, 256}, R ∈ {1, 2, 4, 8}, all modes, odd and even m: compare against the reference model and check latency exactly.
